// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE,
      PARITY_EVEN,
      PARITY_ODD
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic logic calc_parity(input logic [7:0] data, input parity_t mode);
      case (mode)
         PARITY_EVEN: calc_parity = ^data;
         PARITY_ODD:  calc_parity = ~^data;
         default:     calc_parity = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CYCLES_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
   parameter int CYCLES_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic o_bit_end
);

   localparam int W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES_PER_BIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign o_bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, LSB-first frame out on an idle-high line.
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | start bit (low)
//   DATA   | eight data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | one or two stop bits (high)
module uart_tx
   import uart_pkg::*;
#(
   parameter int      CLOCK_FREQUENCY = 50000000,
   parameter int      BAUD            = 115200,
   parameter int      CYCLES_PER_BIT  = CLOCK_FREQUENCY / BAUD,
   parameter parity_t PARITY          = PARITY_NONE,
   parameter int      STOP_BITS       = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_Tx_Byte,
   input  logic       i_Tx_valid,
   output logic       o_Tx_ready,
   output logic       o_Tx,
   output logic       o_Tx_busy,
   output logic       o_Tx_done
);

   if (CYCLES_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx: CYCLES_PER_BIT must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   tx_state_t  state;
   logic [7:0] shreg;
   logic       parity_bit;
   logic [2:0] bit_index;
   logic       stop_index;
   logic       bit_end;
   logic       stop_last;

   assign o_Tx_ready = (state == IDLE);
   assign stop_last  = (STOP_BITS == 1) || stop_index;

   uart_bit_timer #(
      .CYCLES_PER_BIT(CYCLES_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state == IDLE),
      .o_bit_end(bit_end)
   );

   // The state name PARITY is shadowed by the parameter, so it is scoped explicitly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         o_Tx       <= 1'b1;
         o_Tx_busy  <= 1'b0;
         o_Tx_done  <= 1'b0;
         shreg      <= '0;
         parity_bit <= 1'b0;
         bit_index  <= '0;
         stop_index <= 1'b0;
      end else begin
         o_Tx_done <= 1'b0;
         case (state)
            IDLE: begin
               o_Tx       <= 1'b1;
               o_Tx_busy  <= 1'b0;
               bit_index  <= '0;
               stop_index <= 1'b0;
               if (i_Tx_valid && o_Tx_ready) begin
                  shreg      <= i_Tx_Byte;
                  parity_bit <= calc_parity(i_Tx_Byte, PARITY);
                  state      <= START;
                  o_Tx       <= 1'b0;
                  o_Tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state <= DATA;
                  o_Tx  <= shreg[0];
                  shreg <= shreg >> 1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_index == 3'd7) begin
                     if (PARITY != PARITY_NONE) begin
                        state <= uart_pkg::PARITY;
                        o_Tx  <= parity_bit;
                     end else begin
                        state <= STOP;
                        o_Tx  <= 1'b1;
                     end
                  end else begin
                     bit_index <= bit_index + 3'd1;
                     o_Tx      <= shreg[0];
                     shreg     <= shreg >> 1;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  o_Tx  <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (stop_last) begin
                     state     <= IDLE;
                     o_Tx_busy <= 1'b0;
                     o_Tx_done <= 1'b1;
                  end else begin
                     stop_index <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit across parity and stop-bit variants.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CPB = 10;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic [3:0] ready, tx, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits
   uart_tx #(.CLOCK_FREQUENCY(1000000), .BAUD(100000), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_none (
      .clk(clk), .rst_n(rst_n), .i_Tx_Byte(tx_byte), .i_Tx_valid(tx_valid),
      .o_Tx_ready(ready[0]), .o_Tx(tx[0]), .o_Tx_busy(busy[0]), .o_Tx_done(done[0]));
   uart_tx #(.CLOCK_FREQUENCY(1000000), .BAUD(100000), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_even (
      .clk(clk), .rst_n(rst_n), .i_Tx_Byte(tx_byte), .i_Tx_valid(tx_valid),
      .o_Tx_ready(ready[1]), .o_Tx(tx[1]), .o_Tx_busy(busy[1]), .o_Tx_done(done[1]));
   uart_tx #(.CLOCK_FREQUENCY(1000000), .BAUD(100000), .PARITY(PARITY_ODD), .STOP_BITS(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .i_Tx_Byte(tx_byte), .i_Tx_valid(tx_valid),
      .o_Tx_ready(ready[2]), .o_Tx(tx[2]), .o_Tx_busy(busy[2]), .o_Tx_done(done[2]));
   uart_tx #(.CLOCK_FREQUENCY(1000000), .BAUD(100000), .PARITY(PARITY_NONE), .STOP_BITS(2)) dut_stop2 (
      .clk(clk), .rst_n(rst_n), .i_Tx_Byte(tx_byte), .i_Tx_valid(tx_valid),
      .o_Tx_ready(ready[3]), .o_Tx(tx[3]), .o_Tx_busy(busy[3]), .o_Tx_done(done[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tx_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Handshake one byte into dut_none; returns in the first start-bit cycle.
   task automatic start_tx(input logic [7:0] b);
      int n = 0;
      while (!ready[0] && n < 300) begin
         tick();
         n++;
      end
      check("wait_ready", ready[0], 1);
      tx_byte  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   // Called in the first start-bit cycle; returns in the done cycle.
   task automatic run_frame(input int idx, input logic [7:0] b, input int par,
                            input int nstop, input string tag);
      logic exp_bits[$];
      int   busy_cnt = 0;
      int   done_cnt = 0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      if (par == 1) exp_bits.push_back(^b);
      if (par == 2) exp_bits.push_back(~^b);
      for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
      for (int k = 0; k < exp_bits.size(); k++) begin
         int match = 0;
         for (int c = 0; c < CPB; c++) begin
            if (tx[idx] === exp_bits[k]) match++;
            if (busy[idx]) busy_cnt++;
            if (done[idx]) done_cnt++;
            tick();
         end
         check($sformatf("%s bit%0d", tag, k), match, CPB);
      end
      check({tag, " busy_len"}, busy_cnt, exp_bits.size() * CPB);
      check({tag, " early_done"}, done_cnt, 0);
      check({tag, " done"}, done[idx], 1);
      check({tag, " ready_at_done"}, ready[idx], 1);
      check({tag, " idle_line"}, tx[idx], 1);
      check({tag, " busy_at_done"}, busy[idx], 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      repeat (3) tick();
      check("rst tx", tx[0], 1);
      check("rst busy", busy[0], 0);
      check("rst done", done[0], 0);
      check("rst ready", ready[0], 1);

      tx_valid = 1'b1;
      tx_byte  = 8'hAA;
      tick();
      check("rst_drop busy", busy[0], 0);
      check("rst_drop tx", tx[0], 1);
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      tick();

      check("pre_a5 tx", tx[0], 1);
      start_tx(8'hA5);
      run_frame(0, 8'hA5, 0, 1, "a5");
      tick();
      check("a5 done_single", done[0], 0);

      do_reset();
      start_tx(8'hA5);
      fork
         run_frame(0, 8'hA5, 0, 1, "par_none");
         run_frame(1, 8'hA5, 1, 1, "par_even");
         run_frame(2, 8'hA5, 2, 1, "par_odd");
      join

      do_reset();
      start_tx(8'h00);
      fork
         run_frame(0, 8'h00, 0, 1, "z_1stop");
         run_frame(3, 8'h00, 0, 2, "z_2stop");
      join
      tick();
      check("z_2stop done_single", done[3], 0);

      // valid held across two frames
      do_reset();
      tx_byte  = 8'h55;
      tx_valid = 1'b1;
      tick();
      tx_byte = 8'hAA;
      run_frame(0, 8'h55, 0, 1, "b2b_55");
      tick();
      tx_valid = 1'b0;
      run_frame(0, 8'hAA, 0, 1, "b2b_aa");

      // byte changes and stray valid pulses during a frame
      do_reset();
      start_tx(8'h3C);
      tx_byte = 8'hFF;
      fork
         run_frame(0, 8'h3C, 0, 1, "hold_3c");
         begin
            repeat (20) tick();
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            repeat (30) tick();
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
         end
      join
      repeat (2) tick();
      check("ignored_valid tx", tx[0], 1);
      check("ignored_valid busy", busy[0], 0);

      // reset in the middle of data bit 3
      do_reset();
      start_tx(8'hF0);
      repeat (45) tick();
      check("mid bit3", tx[0], 0);
      check("mid busy", busy[0], 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst tx", tx[0], 1);
      check("mid_rst busy", busy[0], 0);
      check("mid_rst ready", ready[0], 1);
      check("mid_rst done", done[0], 0);
      begin
         int dn = 0;
         int lo = 0;
         for (int i = 0; i < 15; i++) begin
            tick();
            if (done[0]) dn++;
            if (!tx[0]) lo++;
         end
         check("post_rst done_cnt", dn, 0);
         check("post_rst low_cnt", lo, 0);
      end
      start_tx(8'h81);
      run_frame(0, 8'h81, 0, 1, "after_rst_81");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
